// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetches 32-bit MIPS instruction words over a req/ack memory handshake.
//   Each fetched word is held and offered downstream over a valid/ready
//   handshake, with the decode fields split out. Only one memory request is
//   outstanding at a time, and the next fetch does not start until the held
//   instruction has been accepted. A redirect squashes the held instruction
//   and any in-flight fetch.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ImemReq/ImemAddr     fetch request and address; both held until ImemAck
//   ImemAck/ImemData     one-cycle response pulse and instruction word
//   IfValid/IfReady      downstream handshake for the held instruction
//   OpCode..Imm16        combinational field slices of the held instruction
//   PCPlus4              address of the held instruction + PC_STEP
//   Redirect/RedirectPC  squash and refetch from RedirectPC (word aligned)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        IfValid,
  input  logic        IfReady,
  output logic [5:0]  OpCode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Imm16,
  output logic [31:0] PCPlus4,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_instr;
  logic [31:0] r_pcplus4;
  logic        r_valid;
  logic        r_drop;
  logic        r_req;

  logic        w_ack;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_next;

  // r_req is only ever set while in FETCH, so an ack outside an active
  // request (HOLD, or the first cycle after reset) is ignored here.
  assign w_ack      = ImemAck & r_req;
  assign w_redir_pc = {RedirectPC[31:2], 2'b00};
  assign w_pc_next  = r_pc + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_instr     <= '0;
      r_pcplus4   <= '0;
      r_valid     <= 1'b0;
      r_drop      <= 1'b0;
      r_req       <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_req <= 1'b1;
          if (w_ack) begin
            r_drop <= 1'b0;
            if (Redirect) begin
              r_pc    <= w_redir_pc;
              r_valid <= 1'b0;
            end else if (!r_drop) begin
              r_instr   <= ImemData;
              r_pcplus4 <= w_pc_next;
              r_pc      <= w_pc_next;
              r_valid   <= 1'b1;
              r_req     <= 1'b0;
              r_state   <= HOLD;
            end
          end else if (Redirect) begin
            r_pc    <= w_redir_pc;
            r_valid <= 1'b0;
            // A request is in flight: keep presenting its address until the
            // ack arrives, then discard that response. Later redirects only
            // move r_pc.
            if (r_req && !r_drop) begin
              r_drop      <= 1'b1;
              r_drop_addr <= r_pc;
            end
          end
        end
        HOLD: begin
          if (Redirect) begin
            r_pc    <= w_redir_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end else if (r_valid && IfReady) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign ImemReq  = r_req;
  assign ImemAddr = r_drop ? r_drop_addr : r_pc;
  assign IfValid  = r_valid & ~Redirect;
  assign OpCode   = r_instr[31:26];
  assign Rs       = r_instr[25:21];
  assign Rt       = r_instr[20:16];
  assign Rd       = r_instr[15:11];
  assign Shamt    = r_instr[10:6];
  assign Funct    = r_instr[5:0];
  assign Imm16    = r_instr[15:0];
  assign PCPlus4  = r_pcplus4;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the decode interface: fetches 32-bit MIPS instructions from instruction memory and presents OpCode plus the split fields to the control unit and register file.
- Holds the PC and handles variable-latency memory with a req/ack handshake.
- Delivers instructions downstream through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that squashes in-flight and held instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ImemReq  out  1  fetch request, held until ImemAck
- ImemAddr  out  32  fetch address, stable while ImemReq=1
- ImemAck  in  1  one-cycle pulse: ImemData valid
- ImemData  in  32  fetched instruction word
- IfValid  out  1  held instruction valid (gated by Redirect)
- IfReady  in  1  downstream accepts the held instruction
- OpCode  out  6  Instr[31:26]
- Rs  out  5  Instr[25:21]
- Rt  out  5  Instr[20:16]
- Rd  out  5  Instr[15:11]
- Shamt  out  5  Instr[10:6]
- Funct  out  6  Instr[5:0]
- Imm16  out  16  Instr[15:0]
- PCPlus4  out  32  address of the held instruction + 4
- Redirect  in  1  squash and refetch from RedirectPC
- RedirectPC  in  32  new fetch address; bits [1:0] forced to 0

Behaviour:
- Clock and reset: single clock domain. rst_n=0 asynchronously sets:
  - pc=RESET_PC, state=FETCH, instr_q=0, valid_q=0, drop_q=0.
  - All field outputs and PCPlus4 read 0.
  - ImemReq=0 while rst_n=0.
  - ImemReq=1 from the first edge after rst_n deasserts.
- State FETCH:
  - ImemReq=1, ImemAddr=pc.
  - On ImemAck with drop_q=0 and Redirect=0: instr_q<=ImemData, PCPlus4<=pc+PC_STEP, pc<=pc+PC_STEP, valid_q<=1, go to HOLD.
  - Minimum latency from request to IfValid is 1 cycle after ack.
- State HOLD:
  - ImemReq=0, IfValid=valid_q & ~Redirect.
  - IfValid&IfReady: valid_q<=0, go to FETCH. The next ImemReq is asserted the following cycle (no prefetch; at most one outstanding request).
  - IfReady=0: all outputs hold.
- Redirect (any state, any cycle):
  - pc<=RedirectPC & ~3.
  - valid_q<=0.
  - IfValid is combinationally forced 0 in the same cycle, so a handshake is never completed on a redirect cycle.
- Redirect in FETCH with no ack that cycle:
  - drop_q<=1; ImemReq and ImemAddr stay unchanged until ImemAck.
  - The ack data is discarded, drop_q<=0, and the next cycle requests the new pc.
- Redirect in FETCH on the same cycle as ImemAck: data discarded, no drop flag; next cycle requests RedirectPC.
- Redirect in HOLD: go to FETCH; next cycle ImemAddr=RedirectPC.
- Redirect while drop_q=1: pc updates to the latest target; drop_q stays 1 until the pending ack arrives.
- Arithmetic: pc wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 0). No overflow flag.
- Ignored inputs:
  - ImemAck outside FETCH is ignored.
  - Field outputs are combinational slices of instr_q and are stable while IfValid=1.
- Reset mid-operation: pending request abandoned; any late ImemAck after reset is consumed as the response to the new RESET_PC request only if it arrives while ImemReq=1. Memory must drop outstanding requests on reset.

Test Plan:
- Reset then ImemAck 2 cycles after ImemReq with ImemData=32'h8C22_0004 (lw), IfReady=1 -> ImemAddr=0; IfValid=1 with OpCode=6'b100011, Rs=1, Rt=2, Imm16=4, PCPlus4=4; next ImemAddr=4.
- R-type 32'h0022_1820 (add) with IfReady=0 for 3 cycles -> IfValid and fields held, ImemReq=0. IfReady=1 -> one transfer only, then ImemAddr=8.
- Redirect=1, RedirectPC=32'h0000_0042 while waiting for ack -> ImemAddr stays unchanged until ack, data discarded, IfValid stays 0, next ImemAddr=32'h0000_0040.
- Redirect during HOLD with IfReady=1 -> IfValid=0 that cycle (no transfer), next ImemAddr=RedirectPC.
- RESET_PC=32'hFFFF_FFFC, one fetch -> PCPlus4=0, next ImemAddr=0.
- rst_n pulled low in HOLD with beq 32'h1000_FFFF -> IfValid=0, OpCode=0 immediately, ImemAddr=RESET_PC after release.
